// File: rtl/alu_cdb_unit_pkg.sv
// Shared definitions for the ALU execution stage and its CDB result buffer.
// Holds widths, the decoder's internal opcode encoding and the buffered entry type.
// No logic; imported by alu_core and alu_cdb_unit.
package alu_cdb_unit_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_W     = 4;
  localparam int OP_W      = 6;
  localparam int BUF_DEPTH = 2;

  // Tag driven on the CDB when nothing is being broadcast.
  localparam logic [ROB_W-1:0] ROBNOTRENAME = '0;

  // Decoder opcode encoding; code 0 and codes past OP_BGEU are undefined ops.
  typedef enum logic [OP_W-1:0] {
    OP_UNDEF = 6'd0,
    OP_ADD,  OP_SUB,  OP_SLL,  OP_SLT,  OP_SLTU, OP_XOR,  OP_SRL,  OP_SRA,  OP_OR,   OP_AND,
    OP_ADDI, OP_SLLI, OP_SLTI, OP_SLTIU, OP_XORI, OP_SRLI, OP_SRAI, OP_ORI, OP_ANDI,
    OP_LUI,  OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ,  OP_BNE,  OP_BLT,  OP_BGE,  OP_BLTU, OP_BGEU
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0]  value;
    logic [ROB_W-1:0] rename;
    logic             jump;
    logic [XLEN-1:0]  target;
  } alu_entry_t;

endpackage

// File: rtl/alu_core.sv
// Purpose: combinational RV32I integer/branch datapath, op -> {value, jump, target}.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
// Ports: op_i opcode; rs1_i/rs2_i operands; imm_i immediate; pc_i instruction PC;
//        value_o result, jump_o control transfer taken, target_o next PC.
module alu_core
  import alu_cdb_unit_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] value_o,
  output logic            jump_o,
  output logic [XLEN-1:0] target_o
);

  logic            is_r;
  logic [XLEN-1:0] opb;
  logic [4:0]      shamt;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] jalr_sum;
  logic            br_taken;

  // Register-register ops take rs2; everything else takes the immediate.
  always_comb begin
    is_r = 1'b0;
    case (op_i)
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
      OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: is_r = 1'b1;
      default:                               is_r = 1'b0;
    endcase
  end

  assign opb         = is_r ? rs2_i : imm_i;
  assign shamt       = opb[4:0];
  assign pc_plus4    = pc_i + 32'd4;
  assign pc_plus_imm = pc_i + imm_i;
  assign jalr_sum    = rs1_i + imm_i;

  always_comb begin
    br_taken = 1'b0;
    case (op_i)
      OP_BEQ:  br_taken = (rs1_i == rs2_i);
      OP_BNE:  br_taken = (rs1_i != rs2_i);
      OP_BLT:  br_taken = ($signed(rs1_i) <  $signed(rs2_i));
      OP_BGE:  br_taken = ($signed(rs1_i) >= $signed(rs2_i));
      OP_BLTU: br_taken = (rs1_i <  rs2_i);
      OP_BGEU: br_taken = (rs1_i >= rs2_i);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    value_o  = '0;
    jump_o   = 1'b0;
    target_o = pc_plus4;
    case (op_i)
      OP_ADD,  OP_ADDI:  value_o = rs1_i + opb;
      OP_SUB:            value_o = rs1_i - opb;
      OP_SLL,  OP_SLLI:  value_o = rs1_i << shamt;
      OP_SRL,  OP_SRLI:  value_o = rs1_i >> shamt;
      OP_SRA,  OP_SRAI:  value_o = $signed(rs1_i) >>> shamt;
      OP_SLT,  OP_SLTI:  value_o = {{(XLEN-1){1'b0}}, ($signed(rs1_i) < $signed(opb))};
      OP_SLTU, OP_SLTIU: value_o = {{(XLEN-1){1'b0}}, (rs1_i < opb)};
      OP_XOR,  OP_XORI:  value_o = rs1_i ^ opb;
      OP_OR,   OP_ORI:   value_o = rs1_i | opb;
      OP_AND,  OP_ANDI:  value_o = rs1_i & opb;
      OP_LUI:            value_o = imm_i;
      OP_AUIPC:          value_o = pc_plus_imm;
      OP_JAL: begin
        value_o  = pc_plus4;
        jump_o   = 1'b1;
        target_o = pc_plus_imm;
      end
      OP_JALR: begin
        value_o  = pc_plus4;
        jump_o   = 1'b1;
        target_o = {jalr_sum[XLEN-1:1], 1'b0};
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        jump_o   = br_taken;
        target_o = br_taken ? pc_plus_imm : pc_plus4;
      end
      // Undefined ops still produce a broadcast so the ROB can retire the tag.
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_cdb_unit.sv
// Purpose: ALU execution stage with a 2-entry result FIFO driving the ALU CDB broadcast.
// Latency: issue captured at edge N is broadcast in cycle N+1 when the buffer has room at its head.
// Backpressure: alu_ready drops when both entries are full; head is held until cdb_grant.
// Ports: clk/rst_n/rdy/clr control; issue_* from the RS; alu_ready to the RS;
//        cdb_grant from the arbiter; alu_broadcast/alu_cbd_value/alu_update_rename/
//        alu_jump/alu_target_pc form the CDB broadcast of the head entry.
module alu_cdb_unit
  import alu_cdb_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             clr,
  input  logic             issue_valid,
  input  logic [ROB_W-1:0] issue_rd_rename,
  input  logic [XLEN-1:0]  issue_rs1_value,
  input  logic [XLEN-1:0]  issue_rs2_value,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [XLEN-1:0]  issue_imm,
  input  logic [XLEN-1:0]  issue_pc,
  output logic             alu_ready,
  input  logic             cdb_grant,
  output logic             alu_broadcast,
  output logic [XLEN-1:0]  alu_cbd_value,
  output logic [ROB_W-1:0] alu_update_rename,
  output logic             alu_jump,
  output logic [XLEN-1:0]  alu_target_pc
);

  alu_entry_t buf_q [BUF_DEPTH];
  alu_entry_t new_entry;
  alu_entry_t head_entry;
  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  alu_core u_core (
    .op_i     (issue_op),
    .rs1_i    (issue_rs1_value),
    .rs2_i    (issue_rs2_value),
    .imm_i    (issue_imm),
    .pc_i     (issue_pc),
    .value_o  (new_entry.value),
    .jump_o   (new_entry.jump),
    .target_o (new_entry.target)
  );
  assign new_entry.rename = issue_rd_rename;

  assign alu_ready     = (count_q != 2'd2);
  assign alu_broadcast = (count_q != 2'd0);

  // rdy gates everything, including the flush; clr beats both push and pop.
  assign push = rdy & ~clr & issue_valid & alu_ready;
  assign pop  = rdy & ~clr & alu_broadcast & cdb_grant;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy && clr) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) tail_d = ~tail_q;
      if (pop)  head_d = ~head_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) buf_q[tail_q] <= new_entry;
    end
  end

  // Outputs are forced to zero while idle so stale entries never reach the CDB.
  assign head_entry        = buf_q[head_q];
  assign alu_cbd_value     = alu_broadcast ? head_entry.value  : '0;
  assign alu_update_rename = alu_broadcast ? head_entry.rename : ROBNOTRENAME;
  assign alu_jump          = alu_broadcast & head_entry.jump;
  assign alu_target_pc     = alu_broadcast ? head_entry.target : '0;

endmodule

// File: tb/tb_alu_cdb_unit.sv
module tb_alu_cdb_unit;
  import alu_cdb_unit_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rdy = 1'b0;
  logic             clr = 1'b0;
  logic             issue_valid = 1'b0;
  logic [ROB_W-1:0] issue_rd_rename = '0;
  logic [XLEN-1:0]  issue_rs1_value = '0;
  logic [XLEN-1:0]  issue_rs2_value = '0;
  logic [OP_W-1:0]  issue_op = '0;
  logic [XLEN-1:0]  issue_imm = '0;
  logic [XLEN-1:0]  issue_pc = '0;
  logic             cdb_grant = 1'b0;
  logic             alu_ready;
  logic             alu_broadcast;
  logic [XLEN-1:0]  alu_cbd_value;
  logic [ROB_W-1:0] alu_update_rename;
  logic             alu_jump;
  logic [XLEN-1:0]  alu_target_pc;

  alu_cdb_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rdy               (rdy),
    .clr               (clr),
    .issue_valid       (issue_valid),
    .issue_rd_rename   (issue_rd_rename),
    .issue_rs1_value   (issue_rs1_value),
    .issue_rs2_value   (issue_rs2_value),
    .issue_op          (issue_op),
    .issue_imm         (issue_imm),
    .issue_pc          (issue_pc),
    .alu_ready         (alu_ready),
    .cdb_grant         (cdb_grant),
    .alu_broadcast     (alu_broadcast),
    .alu_cbd_value     (alu_cbd_value),
    .alu_update_rename (alu_update_rename),
    .alu_jump          (alu_jump),
    .alu_target_pc     (alu_target_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] value;
    logic [3:0]  tag;
    logic        jump;
    logic [31:0] target;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   occ_pre = 0;  // model occupancy just before the coming edge

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: instruction semantics written directly from the RV32I rules.
  function automatic exp_t ref_model(input logic [5:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] imm,
                                     input logic [31:0] pc, input logic [3:0] tag);
    exp_t e;
    bit   is_br;
    bit   taken;
    e.value = 32'd0; e.tag = tag; e.jump = 1'b0; e.target = pc + 32'd4;
    is_br = 1'b0; taken = 1'b0;
    case (op)
      OP_ADD:   e.value = a + b;
      OP_SUB:   e.value = a - b;
      OP_SLL:   e.value = a << b[4:0];
      OP_SRL:   e.value = a >> b[4:0];
      OP_SRA:   e.value = $signed(a) >>> b[4:0];
      OP_SLT:   e.value = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU:  e.value = (a < b) ? 32'd1 : 32'd0;
      OP_XOR:   e.value = a ^ b;
      OP_OR:    e.value = a | b;
      OP_AND:   e.value = a & b;
      OP_ADDI:  e.value = a + imm;
      OP_SLLI:  e.value = a << imm[4:0];
      OP_SRLI:  e.value = a >> imm[4:0];
      OP_SRAI:  e.value = $signed(a) >>> imm[4:0];
      OP_SLTI:  e.value = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
      OP_SLTIU: e.value = (a < imm) ? 32'd1 : 32'd0;
      OP_XORI:  e.value = a ^ imm;
      OP_ORI:   e.value = a | imm;
      OP_ANDI:  e.value = a & imm;
      OP_LUI:   e.value = imm;
      OP_AUIPC: e.value = pc + imm;
      OP_JAL:   begin e.value = pc + 32'd4; e.jump = 1'b1; e.target = pc + imm; end
      OP_JALR:  begin e.value = pc + 32'd4; e.jump = 1'b1; e.target = (a + imm) & 32'hFFFF_FFFE; end
      OP_BEQ:   begin is_br = 1'b1; taken = (a == b); end
      OP_BNE:   begin is_br = 1'b1; taken = (a != b); end
      OP_BLT:   begin is_br = 1'b1; taken = ($signed(a) <  $signed(b)); end
      OP_BGE:   begin is_br = 1'b1; taken = ($signed(a) >= $signed(b)); end
      OP_BLTU:  begin is_br = 1'b1; taken = (a <  b); end
      OP_BGEU:  begin is_br = 1'b1; taken = (a >= b); end
      default:  ;
    endcase
    if (is_br) begin
      e.jump   = taken;
      e.target = taken ? pc + imm : pc + 32'd4;
    end
    return e;
  endfunction

  // Monitor: compares every visible broadcast with the scoreboard head and retires it on grant.
  always @(negedge clk) begin
    occ_pre = exp_q.size();
    if (rst_n) begin
      chk("alu_ready", {31'd0, alu_ready}, {31'd0, occ_pre != 2});
      chk("alu_broadcast", {31'd0, alu_broadcast}, {31'd0, occ_pre != 0});
      if (alu_broadcast && occ_pre > 0) begin
        chk("cdb_value", alu_cbd_value, exp_q[0].value);
        chk("cdb_rename", {28'd0, alu_update_rename}, {28'd0, exp_q[0].tag});
        chk("cdb_jump", {31'd0, alu_jump}, {31'd0, exp_q[0].jump});
        chk("cdb_target", alu_target_pc, exp_q[0].target);
        if (rdy && !clr && cdb_grant) void'(exp_q.pop_front());
      end
    end
  end

  // One clock: at the edge, record what the unit accepts (or flushes), then move off the edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n && rdy) begin
      if (clr) exp_q.delete();
      else if (issue_valid && occ_pre < 2)
        exp_q.push_back(ref_model(issue_op, issue_rs1_value, issue_rs2_value,
                                  issue_imm, issue_pc, issue_rd_rename));
    end
    #2;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
    issue_valid = 1'b1; issue_op = op; issue_rs1_value = a; issue_rs2_value = b;
    issue_imm = imm; issue_pc = pc; issue_rd_rename = tag;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 3))
      0:       return $urandom();
      1:       return 32'($urandom_range(0, 40));
      2:       return ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      default: return 32'($urandom_range(0, 255)) << 4;
    endcase
  endfunction

  initial begin
    // Reset state
    #12;
    chk("rst_broadcast", {31'd0, alu_broadcast}, 32'd0);
    chk("rst_ready", {31'd0, alu_ready}, 32'd1);
    chk("rst_value", alu_cbd_value, 32'd0);
    chk("rst_rename", {28'd0, alu_update_rename}, 32'd0);
    chk("rst_jump", {31'd0, alu_jump}, 32'd0);
    chk("rst_target", alu_target_pc, 32'd0);
    rst_n = 1'b1;
    rdy   = 1'b1;

    // Single ADD with grant: one-cycle broadcast
    cdb_grant = 1'b1;
    issue(OP_ADD, 32'd5, 32'd7, 32'd0, 32'h200, 4'd3);
    cycle();
    idle();
    chk("add_value", alu_cbd_value, 32'd12);
    chk("add_rename", {28'd0, alu_update_rename}, 32'd3);
    chk("add_target", alu_target_pc, 32'h204);
    cycle();
    chk("add_gone", {31'd0, alu_broadcast}, 32'd0);

    // Fill under no grant, ignored issue while full, then drain one
    cdb_grant = 1'b0;
    issue(OP_SUB, 32'd1, 32'd2, 32'd0, 32'h10, 4'd1);
    cycle();
    issue(OP_SRA, 32'h8000_0000, 32'd4, 32'd0, 32'h14, 4'd2);
    cycle();
    issue(OP_ADD, 32'd1, 32'd1, 32'd0, 32'h18, 4'hF);
    cycle();
    idle();
    chk("full_ready", {31'd0, alu_ready}, 32'd0);
    chk("full_head_value", alu_cbd_value, 32'hFFFF_FFFF);
    chk("full_head_rename", {28'd0, alu_update_rename}, 32'd1);
    cycle();
    chk("hold_value", alu_cbd_value, 32'hFFFF_FFFF);
    cdb_grant = 1'b1;
    cycle();
    chk("pop_value", alu_cbd_value, 32'hF800_0000);
    chk("pop_rename", {28'd0, alu_update_rename}, 32'd2);
    chk("pop_ready", {31'd0, alu_ready}, 32'd1);

    // Simultaneous push and pop at count=1
    issue(OP_ADDI, 32'd10, 32'd0, 32'd1, 32'h20, 4'd5);
    cycle();
    idle();
    chk("pp_rename", {28'd0, alu_update_rename}, 32'd5);
    chk("pp_value", alu_cbd_value, 32'd11);
    chk("pp_ready", {31'd0, alu_ready}, 32'd1);
    cycle();

    // Branches and JALR
    issue(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd6);
    cycle();
    chk("blt_jump", {31'd0, alu_jump}, 32'd1);
    chk("blt_target", alu_target_pc, 32'h120);
    chk("blt_value", alu_cbd_value, 32'd0);
    issue(OP_BGE, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd7);
    cycle();
    chk("bge_jump", {31'd0, alu_jump}, 32'd0);
    chk("bge_target", alu_target_pc, 32'h104);
    issue(OP_BGEU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd8);
    cycle();
    chk("bgeu_jump", {31'd0, alu_jump}, 32'd1);
    chk("bgeu_target", alu_target_pc, 32'h120);
    issue(OP_JALR, 32'h1003, 32'd0, 32'd2, 32'h40, 4'd9);
    cycle();
    chk("jalr_value", alu_cbd_value, 32'h44);
    chk("jalr_target", alu_target_pc, 32'h1004);
    chk("jalr_jump", {31'd0, alu_jump}, 32'd1);
    issue(6'd63, 32'd1, 32'd2, 32'd3, 32'h300, 4'd10);
    cycle();
    idle();
    chk("undef_bcast", {31'd0, alu_broadcast}, 32'd1);
    chk("undef_value", alu_cbd_value, 32'd0);
    chk("undef_target", alu_target_pc, 32'h304);
    cycle();

    // Flush with a same-cycle issue
    cdb_grant = 1'b0;
    issue(OP_ADD, 32'd100, 32'd1, 32'd0, 32'h50, 4'd11);
    cycle();
    issue(OP_ADD, 32'd200, 32'd1, 32'd0, 32'h54, 4'd12);
    cycle();
    issue(OP_ADD, 32'd300, 32'd1, 32'd0, 32'h58, 4'd13);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    idle();
    chk("clr_bcast", {31'd0, alu_broadcast}, 32'd0);
    chk("clr_ready", {31'd0, alu_ready}, 32'd1);
    cycle();
    chk("clr_stays_empty", {31'd0, alu_broadcast}, 32'd0);

    // Async reset while holding a broadcast
    issue(OP_XOR, 32'hF0F0, 32'h0FF0, 32'd0, 32'h60, 4'd14);
    cycle();
    issue(OP_OR, 32'h1, 32'h2, 32'd0, 32'h64, 4'd15);
    cycle();
    idle();
    rst_n = 1'b0;
    #1;
    chk("arst_bcast", {31'd0, alu_broadcast}, 32'd0);
    chk("arst_value", alu_cbd_value, 32'd0);
    chk("arst_rename", {28'd0, alu_update_rename}, 32'd0);
    chk("arst_target", alu_target_pc, 32'd0);
    chk("arst_ready", {31'd0, alu_ready}, 32'd1);
    exp_q.delete();
    #10;
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] a;
      rdy         = ($urandom_range(0, 9) != 0);
      clr         = ($urandom_range(0, 39) == 0);
      cdb_grant   = ($urandom_range(0, 9) < 6);
      a           = pick_operand();
      issue(6'($urandom_range(0, 31)), a,
            ($urandom_range(0, 3) == 0) ? a : pick_operand(),
            pick_operand(), $urandom() & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)));
      issue_valid = ($urandom_range(0, 9) < 7);
      cycle();
    end

    // Drain with a bounded wait
    rdy = 1'b1; clr = 1'b0; cdb_grant = 1'b1;
    idle();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle();
    cycle();
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_bcast", {31'd0, alu_broadcast}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
